// File: rtl/ram_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_loader_pkg
//  Brief    : Shared constants and state encoding for the boot-time RAM loader.
//             The RAM geometry constants are the single source for both the
//             data RAM and the loader.
//  Revision : 1.0 - initial release
// ============================================================================
package ram_loader_pkg;

  // Data RAM geometry, shared with the RAM instance at top level
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 16;
  localparam int RAM_DEPTH  = 1 << RAM_ADDR_W;

  // The length header is a big-endian 16-bit word
  localparam int LEN_BYTES = 2;
  localparam int LEN_W     = 8 * LEN_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DAT_HI = 3'd3,
    ST_DAT_LO = 3'd4,
    ST_WRITE  = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ram_loader_ram_port_mux.sv
`default_nettype none
// ============================================================================
//  Module   : ram_port_mux
//  Brief    : Selects who drives the data RAM port: the CPU while it runs,
//             the loader while the CPU is held.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_port_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              cpu_hold,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we
);

  // CPU write enable is fully blocked while held so a stalled CPU cannot corrupt the load
  always_comb begin
    if (cpu_hold) begin
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
      ram_we    = ld_we;
    end else begin
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
      ram_we    = cpu_we;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ram_loader
//  Brief    : Boot-time program loader. Reads a big-endian length header and
//             that many big-endian 16-bit words from a byte stream, writes
//             them to RAM from address 0 while holding the CPU, then releases
//             it. Transparent CPU pass-through when not loading.
//  Revision : 1.0 - initial release
// ============================================================================
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              CPUclk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    length_q, length_d;
  logic [DATA_W-1:0]   word_q, word_d;
  logic [ADDR_W:0]     count_q, count_d;   // one extra bit so a full-depth load does not wrap
  logic [LEN_W-1:0]    len_full;
  logic [LEN_W-1:0]    count_next_ext;
  logic                ld_we;

  // State, length, word and counter registers
  always_ff @(posedge CPUclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      length_q <= '0;
      word_q   <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      word_q   <= word_d;
      count_q  <= count_d;
    end
  end

  // Next-state, byte assembly and counter update; state only moves on a byte transfer
  always_comb begin
    state_d        = state_q;
    length_d       = length_q;
    word_d         = word_q;
    count_d        = count_q;
    byte_ready     = 1'b0;
    ld_we          = 1'b0;
    len_full       = {length_q[LEN_W-1:8], byte_data};
    count_next_ext = {{(LEN_W-ADDR_W-1){1'b0}}, count_q + 1'b1};

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d  = ST_LEN_HI;
          count_d  = '0;
          length_d = '0;
        end
      end
      ST_LEN_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          length_d[LEN_W-1:8] = byte_data;
          state_d             = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          length_d = len_full;
          if (len_full == '0)
            state_d = ST_DONE;
          else if (len_full > LEN_W'(DEPTH))
            state_d = ST_ERR;
          else
            state_d = ST_DAT_HI;
        end
      end
      ST_DAT_HI: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          word_d[DATA_W-1:8] = byte_data;
          state_d            = ST_DAT_LO;
        end
      end
      ST_DAT_LO: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          word_d[7:0] = byte_data;
          state_d     = ST_WRITE;
        end
      end
      ST_WRITE: begin
        ld_we   = 1'b1;
        count_d = count_q + 1'b1;
        if (count_next_ext == length_q)
          state_d = ST_DONE;
        else
          state_d = ST_DAT_HI;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs decode straight from state so reset clears them asynchronously
  always_comb begin
    cpu_hold = (state_q != ST_IDLE) && (state_q != ST_DONE);
    done     = (state_q == ST_DONE);
    err      = (state_q == ST_ERR);
  end

  ram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram_port_mux (
    .cpu_hold  (cpu_hold),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .ld_addr   (count_q[ADDR_W-1:0]),
    .ld_wdata  (word_q),
    .ld_we     (ld_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we)
  );

endmodule
`default_nettype wire

// File: doc/ram_loader.md
Name: ram_loader

Overview:
Boot-time program loader between a byte-stream source (UART receiver or host link) and the 256x16 data RAM. On a start pulse it holds the CPU, assembles big-endian byte pairs into 16-bit words and writes them to consecutive RAM addresses from 0. It then releases the CPU. While idle it is a transparent pass-through of the CPU's RAM address, write-data and write-enable signals.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 16, RAM word width (fixed at 2 bytes per word)
DEPTH, 256, RAM depth in words; largest legal load length

Ports:
CPUclk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse to begin a load
byte_valid  in  1  source has a byte on byte_data
byte_data  in  8  stream byte
byte_ready  out  1  loader accepts byte this cycle (transfer = valid & ready)
cpu_addr  in  ADDR_W  CPU RAM address
cpu_wdata  in  DATA_W  CPU write data
cpu_we  in  1  CPU write enable
ram_addr  out  ADDR_W  to RAM addr
ram_wdata  out  DATA_W  to RAM wdata
ram_we  out  1  to RAM we
cpu_hold  out  1  holds CPU in reset/stall while high
done  out  1  load completed successfully (level)
err  out  1  load aborted, length illegal (level)

Behaviour:
- Reset (async, rst_n=0): state IDLE, cpu_hold=0, done=0, err=0, byte_ready=0, word counter=0, length=0. RAM contents untouched. Reset mid-load aborts immediately and leaves partially written RAM as is.
- States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, DONE, ERR.
- IDLE / DONE / ERR: start=1 -> LEN_HI, cpu_hold=1, done=0, err=0, counter=0. In every other state start is ignored.
- byte_ready=1 only in LEN_HI, LEN_LO, DAT_HI and DAT_LO. State advances only on transfer.
- LEN_HI: latch length[15:8] -> LEN_LO.
- LEN_LO: latch length[7:0], then on the same edge:
  - length==0 -> DONE.
  - length>DEPTH -> ERR.
  - otherwise -> DAT_HI.
- DAT_HI: latch word[15:8] -> DAT_LO.
- DAT_LO: latch word[7:0] -> WRITE.
- WRITE (exactly one cycle): ram_we=1, ram_addr=counter[ADDR_W-1:0], ram_wdata=word. Counter increments. If incremented count==length -> DONE, else -> DAT_HI.
  - Byte-to-write latency: one cycle after the low-byte transfer.
  - Sustained throughput: 1 word per 3 cycles when byte_valid is held high.
- Counter is ADDR_W+1 bits wide, so a load of length DEPTH (256) completes without wrap; the last write goes to address DEPTH-1.
- DONE: cpu_hold=0, done=1 (held until next start).
- ERR: cpu_hold stays 1, err=1; no RAM writes occur.
- RAM port mux (combinational):
  - cpu_hold=0: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we.
  - cpu_hold=1: ram_addr and ram_wdata come from the loader; ram_we=1 only in WRITE; cpu_we is ignored.
- byte_valid without ready (IDLE, WRITE, DONE, ERR) consumes nothing; the source must hold the byte.
- Start pulse during IDLE with byte_valid already high: the byte is not taken in that cycle. It is accepted as LEN_HI on the next cycle.

Decomposition:
- Shared package: state encoding enum and the LEN_BYTES=2 constant; DEPTH/ADDR_W derived from the same package constant the RAM uses.
- One natural sub-module: ram_port_mux (combinational CPU/loader select). The FSM, counter and byte assembly stay in ram_loader.
- RAM itself is instantiated at top level, not inside this block.

Test Plan:
- Reset then idle pass-through: cpu_addr=0x12, cpu_wdata=0xBEEF, cpu_we=1 -> ram_addr=0x12, ram_wdata=0xBEEF, ram_we=1; cpu_hold=0, done=0, err=0.
- Load 3 words: start, then bytes 00 03 12 34 AB CD 00 01 -> RAM[0]=0x1234, RAM[1]=0xABCD, RAM[2]=0x0001; each ram_we exactly 1 cycle after its low byte; done=1 and cpu_hold=0 after the third write.
- Full-depth load: length 0x0100, 256 words with data=address -> RAM[255]=0x00FF; no write to address 0 after the first; done=1. Length 0x0101 -> err=1, cpu_hold=1, zero ram_we pulses.
- Zero length and backpressure: bytes 00 00 -> DONE immediately, no writes. Then a 1-word load with byte_valid toggled 1/0 every cycle -> correct single write, and no byte lost or duplicated.
- Reset mid-load: assert rst_n=0 after the 1st of 2 words -> all outputs at reset values asynchronously; RAM[0] keeps its new value; a new start reloads correctly.
- CPU isolation: cpu_we=1 held throughout a load -> ram_we pulses only in WRITE cycles; after done, CPU writes reach RAM again.
